iq_channel_arbiter: RTL and testbench
=====================================

# iq_channel_arbiter

Round-robin scheduler that shares one I/Q quantizer stage between two streaming I/Q sample sources (channel 0 and channel 1). It grants one channel for a fixed burst of samples and splits each accepted 2×DATA_WIDTH word into I (upper half) and Q (lower half). It truncates both to QUANTIZE_WIDTH bits and presents them on a single registered valid/ready output tagged with channel and end-of-burst. It sits between the per-antenna sample capture and the downstream quantized-sample consumers.

## Interface
- DATA_WIDTH, 16, width of each I and Q component on input
- QUANTIZE_WIDTH, 10, width of each I and Q component on output (must be ≤ DATA_WIDTH)
- BURST_LEN, 64, samples accepted per grant (≥ 1)

- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- s0_valid  in  1  channel 0 sample valid
- s0_data  in  2*DATA_WIDTH  channel 0 sample, I in [2*DATA_WIDTH-1:DATA_WIDTH], Q in [DATA_WIDTH-1:0]
- s0_ready  out  1  channel 0 sample accepted when s0_valid && s0_ready
- s1_valid, s1_data, s1_ready  as channel 0, for channel 1
- m_valid  out  1  output sample valid
- m_ready  in  1  downstream ready
- m_i  out  QUANTIZE_WIDTH  quantized I
- m_q  out  QUANTIZE_WIDTH  quantized Q
- m_chan  out  1  source channel of current output sample
- m_last  out  1  current output sample is the BURST_LEN-th of its burst
- busy  out  1  high whenever state ≠ IDLE or m_valid is high

## Operation
- States: IDLE, GRANT0, GRANT1.
- IDLE: s0_ready = s1_ready = 0. Arbitration evaluates registered last-served pointer `last_chan`.
  - Both valid: go to GRANTx for x ≠ last_chan.
  - One valid: go to that channel's GRANT.
  - None valid: stay in IDLE.
- GRANTx: only channel x may see ready. sx_ready = !m_valid || m_ready (output register free or draining this cycle). The other channel's ready is 0.
- On accept (sx_valid && sx_ready):
  - Load output register: m_i = sx_data[2*DATA_WIDTH-1 -: QUANTIZE_WIDTH], m_q = sx_data[DATA_WIDTH-1 -: QUANTIZE_WIDTH]. This is truncation, equivalent to an unsigned logical right shift by DATA_WIDTH−QUANTIZE_WIDTH. No rounding and no saturation.
  - Set m_chan = x and m_valid = 1. m_last = (burst counter == BURST_LEN−1).
  - Increment burst counter (width clog2(BURST_LEN)+1).
- After the BURST_LEN-th accept: counter clears, last_chan = x, state → IDLE.
- The grant is held until BURST_LEN samples are accepted. Source valid gaps stall the burst and do not end it. The other channel waits.
- Output register: m_valid clears when m_valid && m_ready and no new accept occurs in the same cycle. On simultaneous drain and accept, the new sample replaces the old one and m_valid stays 1.
- m_i, m_q, m_chan, m_last hold stable while m_valid && !m_ready.

## Timing
- Reset (reset == 0 at a clock edge) gives:
  - state = IDLE, counter = 0, last_chan = 1 (so channel 0 wins the first tie)
  - m_valid = 0, m_i = 0, m_q = 0, m_chan = 0, m_last = 0, busy = 0
  - s0_ready = s1_ready = 0
- Reset mid-burst discards the partial burst and any held output sample. There is no m_last for the aborted burst.
- IDLE → GRANTx takes 1 cycle. The earliest accept is in the cycle after the decision.
- Input accept to m_valid: 1 cycle.
- Full throughput is 1 sample/cycle within a burst when m_ready is held high.
- The last accept of a burst is followed by ≥1 IDLE cycle, in which s*_ready = 0. Minimum burst period is BURST_LEN+1 cycles.
- Backpressure: m_ready low with m_valid high forces sx_ready low in the same cycle (combinational from m_valid/m_ready/state).
- Ready must not depend combinationally on sx_valid.

## Test plan
- Reset then single source: after reset, hold s0_valid = 1 with s0_data = 0xABCD_1234 and m_ready = 1.
  - IDLE for 1 cycle, then s0_ready = 1.
  - m_valid 1 cycle after the first accept with m_i = 0x2AF, m_q = 0x048, m_chan = 0.
  - m_last on the 64th output, then 1 cycle with s0_ready = 0.
- Tie and round-robin: both sources valid continuously, m_ready = 1. Expected output m_chan sequence is 64×0, 64×1, 64×0.
  - m_last is set on outputs 64, 128 and 192.
  - The non-granted ready is never high.
- Backpressure: mid-burst, drop m_ready for 5 cycles. m_i/m_q/m_chan/m_last must stay stable and sx_ready must be 0 for those cycles. No sample may be lost or duplicated (check with an incrementing data pattern 0x0040_0040·n).
- Stalled burst: grant channel 0, deassert s0_valid after 10 accepts while s1_valid = 1. Channel 1 is not granted until channel 0 supplies its remaining 54 samples.
- Reset mid-burst: assert reset low for 1 cycle after 20 accepts with m_valid = 1.
  - Next cycle: m_valid = 0, busy = 0, both readies 0.
  - A following tie grants channel 0 and the burst counter restarts (m_last on the 64th new sample).
- Quantize boundaries: I/Q = 0xFFFF/0x0000 gives m_i = 0x3FF, m_q = 0x000. Input 0x003F_8000 gives m_i = 0x000, m_q = 0x200.

Source files
------------

// File: rtl/iq_channel_arbiter.sv
// Round-robin burst arbiter sharing one I/Q truncating quantizer between two
// streaming sources; output is a single registered valid/ready stage.
module iq_channel_arbiter #(
  parameter int DATA_WIDTH     = 16,
  parameter int QUANTIZE_WIDTH = 10,
  parameter int BURST_LEN      = 64
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        s0_valid,
  input  logic [2*DATA_WIDTH-1:0]     s0_data,
  output logic                        s0_ready,
  input  logic                        s1_valid,
  input  logic [2*DATA_WIDTH-1:0]     s1_data,
  output logic                        s1_ready,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [QUANTIZE_WIDTH-1:0]   m_i,
  output logic [QUANTIZE_WIDTH-1:0]   m_q,
  output logic                        m_chan,
  output logic                        m_last,
  output logic                        busy,
  output logic [1:0]                  fsm_state
);

  localparam int CW    = $clog2(BURST_LEN) + 1;
  localparam int SHIFT = DATA_WIDTH - QUANTIZE_WIDTH;
  localparam logic [CW-1:0] LAST_IDX = CW'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_d;
  logic                    last_chan;
  logic [CW-1:0]           count;
  logic                    out_free;
  logic                    accept;
  logic                    burst_done;
  logic [2*DATA_WIDTH-1:0] sel_data;
  logic [QUANTIZE_WIDTH-1:0] q_i;
  logic [QUANTIZE_WIDTH-1:0] q_q;

  // Handshakes: a word moves when valid && ready at a rising edge; ready never
  // looks at valid, and valid/data are held by the sender until accepted.
  assign accept     = (state == GRANT0 && s0_valid && s0_ready) ||
                      (state == GRANT1 && s1_valid && s1_ready);
  assign burst_done = accept && (count == LAST_IDX);
  assign sel_data   = (state == GRANT1) ? s1_data : s0_data;
  assign q_i        = QUANTIZE_WIDTH'(sel_data[2*DATA_WIDTH-1:DATA_WIDTH] >> SHIFT);
  assign q_q        = QUANTIZE_WIDTH'(sel_data[DATA_WIDTH-1:0] >> SHIFT);

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        // The channel not served last wins a tie.
        if (s0_valid && s1_valid) state_d = last_chan ? GRANT0 : GRANT1;
        else if (s0_valid)        state_d = GRANT0;
        else if (s1_valid)        state_d = GRANT1;
      end
      GRANT0, GRANT1: if (burst_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_free  = !m_valid || m_ready;
    s0_ready  = (state == GRANT0) && out_free;
    s1_ready  = (state == GRANT1) && out_free;
    busy      = (state != IDLE) || m_valid;
    fsm_state = state;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      count     <= '0;
      last_chan <= 1'b1;
    end else if (accept) begin
      if (burst_done) begin
        count     <= '0;
        last_chan <= (state == GRANT1);
      end else begin
        count <= count + CW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      m_valid <= 1'b0;
      m_i     <= '0;
      m_q     <= '0;
      m_chan  <= 1'b0;
      m_last  <= 1'b0;
    end else if (accept) begin
      m_valid <= 1'b1;
      m_i     <= q_i;
      m_q     <= q_q;
      m_chan  <= (state == GRANT1);
      m_last  <= (count == LAST_IDX);
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_iq_channel_arbiter.sv
// Randomized and directed bench for iq_channel_arbiter against a
// transaction-level reference model with an expected-output queue.
module tb_iq_channel_arbiter;
  localparam int DW = 16;
  localparam int QW = 10;
  localparam int BL = 64;
  localparam int W  = 2 * QW + 2;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          s0_valid = 1'b0, s1_valid = 1'b0;
  logic [2*DW-1:0] s0_data = '0, s1_data = '0;
  logic          s0_ready, s1_ready;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [QW-1:0] m_i, m_q;
  logic          m_chan, m_last, busy;
  logic [1:0]    fsm_state;

  iq_channel_arbiter #(.DATA_WIDTH(DW), .QUANTIZE_WIDTH(QW), .BURST_LEN(BL)) dut (
    .clock(clock), .reset(reset),
    .s0_valid(s0_valid), .s0_data(s0_data), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_data(s1_data), .s1_ready(s1_ready),
    .m_valid(m_valid), .m_ready(m_ready), .m_i(m_i), .m_q(m_q),
    .m_chan(m_chan), .m_last(m_last), .busy(busy), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // owner: -1 when nobody holds the grant, else the channel holding it.
  logic [W-1:0] exp_q[$];
  int owner = -1;
  int served = 0;
  int prev = 1;
  bit model_ok = 0;

  function automatic logic [QW-1:0] qi(input logic [31:0] w);
    return QW'(w / (32'd1 << (2 * DW - QW)));
  endfunction

  function automatic logic [QW-1:0] qq(input logic [31:0] w);
    return QW'((w % (32'd1 << DW)) / (32'd1 << (DW - QW)));
  endfunction

  always @(posedge clock) begin : model
    int was;
    int acc;
    bit free;
    logic [31:0] word;
    if (!reset) begin
      owner = -1; served = 0; prev = 1; exp_q.delete(); model_ok = 1;
    end else begin
      was  = owner;
      acc  = -1;
      free = (exp_q.size() == 0) || m_ready;
      if (was == 0 && s0_valid && free) acc = 0;
      else if (was == 1 && s1_valid && free) acc = 1;
      if (exp_q.size() != 0 && m_ready) exp_q.delete(0);
      if (acc >= 0) begin
        word = (acc == 1) ? s1_data : s0_data;
        served++;
        exp_q.push_back({(acc == 1), (served == BL), qi(word), qq(word)});
        if (served == BL) begin
          served = 0; prev = acc; owner = -1;
        end
      end else if (was < 0) begin
        if (s0_valid && s1_valid) owner = 1 - prev;
        else if (s0_valid)        owner = 0;
        else if (s1_valid)        owner = 1;
      end
    end
  end

  // ---------------- compare + monitor ----------------
  logic [W-1:0] out_log[$];
  int in_acc0 = 0;
  int in_acc1 = 0;

  always @(negedge clock) begin : compare
    bit fr;
    if (model_ok) begin
      fr = (exp_q.size() == 0) || m_ready;
      chk("s0_ready", s0_ready, (owner == 0) && fr);
      chk("s1_ready", s1_ready, (owner == 1) && fr);
      chk("m_valid", m_valid, exp_q.size() != 0);
      chk("busy", busy, (owner >= 0) || (exp_q.size() != 0));
      if (exp_q.size() != 0) chk("m_word", {m_chan, m_last, m_i, m_q}, exp_q[0]);
    end
    if (m_valid && m_ready) out_log.push_back({m_chan, m_last, m_i, m_q});
    if (s0_valid && s0_ready) in_acc0++;
    if (s1_valid && s1_ready) in_acc1++;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    s0_valid = 0; s1_valid = 0; m_ready = 1; reset = 0;
    repeat (2) step();
    reset = 1;
    out_log.delete(); in_acc0 = 0; in_acc1 = 0;
  endtask

  task automatic run_until(input int n, input int budget, input string name);
    int c = 0;
    while (out_log.size() < n && c < budget) begin step(); c++; end
    chk(name, out_log.size() >= n, 1);
  endtask

  function automatic logic [W-1:0] log_at(input int k);
    if (k < out_log.size()) return out_log[k];
    return '1;
  endfunction

  function automatic logic f_chan(input logic [W-1:0] e); return e[W-1]; endfunction
  function automatic logic f_last(input logic [W-1:0] e); return e[W-2]; endfunction
  function automatic logic [QW-1:0] f_i(input logic [W-1:0] e); return e[2*QW-1:QW]; endfunction
  function automatic logic [QW-1:0] f_q(input logic [W-1:0] e); return e[QW-1:0]; endfunction

  // ---------------- tests ----------------
  initial begin
    logic [W-1:0] snap;
    int bad;
    int c;

    // Model pins: hand-computed truncations.
    chk("model_qi", qi(32'hABCD1234), 32'h2AF);
    chk("model_qq", qq(32'hABCD1234), 32'h048);

    // Reset then single source.
    do_reset();
    chk("rst_m_i", m_i, 0); chk("rst_m_q", m_q, 0);
    chk("rst_m_chan", m_chan, 0); chk("rst_m_last", m_last, 0);
    chk("rst_busy", busy, 0);
    s0_valid = 1; s0_data = 32'hABCD1234;
    @(negedge clock); chk("t1_idle_ready", s0_ready, 0);
    @(negedge clock); chk("t1_grant_ready", s0_ready, 1);
    run_until(64, 200, "t1_outputs");
    chk("t1_first_i", f_i(log_at(0)), 32'h2AF);
    chk("t1_first_q", f_q(log_at(0)), 32'h048);
    chk("t1_first_chan", f_chan(log_at(0)), 0);
    chk("t1_last63", f_last(log_at(63)), 1);
    chk("t1_last62", f_last(log_at(62)), 0);

    // Tie and round-robin.
    do_reset();
    s0_valid = 1; s1_valid = 1;
    c = 0;
    while (out_log.size() < 192 && c < 600) begin
      s0_data = $urandom(); s1_data = $urandom(); step(); c++;
    end
    chk("t2_outputs", out_log.size() >= 192, 1);
    bad = 0;
    for (int k = 0; k < 192; k++) begin
      if (f_chan(log_at(k)) != ((k / 64) == 1)) bad++;
      if (f_last(log_at(k)) != ((k % 64) == 63)) bad++;
    end
    chk("t2_chan_last_seq", bad, 0);

    // Backpressure with incrementing pattern.
    do_reset();
    s0_valid = 1; s0_data = 32'h00400040;
    c = 0;
    while (in_acc0 < 20 && c < 200) begin step(); s0_data = 32'h00400040 * (in_acc0 + 1); c++; end
    m_ready = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("t3_bp_ready", s0_ready, 0);
      chk("t3_bp_valid", m_valid, 1);
      if (k == 0) snap = {m_chan, m_last, m_i, m_q};
      else chk("t3_bp_hold", {m_chan, m_last, m_i, m_q}, snap);
      step(); s0_data = 32'h00400040 * (in_acc0 + 1);
    end
    m_ready = 1;
    c = 0;
    while (out_log.size() < 64 && c < 300) begin step(); s0_data = 32'h00400040 * (in_acc0 + 1); c++; end
    chk("t3_outputs", out_log.size() >= 64, 1);
    bad = 0;
    for (int k = 0; k < 64; k++)
      if (f_i(log_at(k)) != QW'(k + 1) || f_q(log_at(k)) != QW'(k + 1)) bad++;
    chk("t3_no_loss_dup", bad, 0);

    // Stalled burst keeps the grant.
    do_reset();
    s0_valid = 1; s1_valid = 1;
    c = 0;
    while (in_acc0 < 10 && c < 100) begin step(); c++; end
    s0_valid = 0;
    repeat (30) step();
    chk("t4_stall_acc0", in_acc0, 10);
    chk("t4_stall_acc1", in_acc1, 0);
    s0_valid = 1;
    run_until(70, 300, "t4_outputs");
    chk("t4_ch0_end", f_last(log_at(63)), 1);
    chk("t4_ch1_next", f_chan(log_at(64)), 1);

    // Reset mid-burst.
    do_reset();
    s0_valid = 1;
    c = 0;
    while (in_acc0 < 20 && c < 100) begin step(); c++; end
    @(negedge clock); chk("t5_pre_valid", m_valid, 1);
    reset = 0; step(); reset = 1; s0_valid = 0;
    out_log.delete(); in_acc0 = 0; in_acc1 = 0;
    @(negedge clock);
    chk("t5_m_valid", m_valid, 0); chk("t5_busy", busy, 0);
    chk("t5_s0_ready", s0_ready, 0); chk("t5_s1_ready", s1_ready, 0);
    step();
    s0_valid = 1; s1_valid = 1;
    run_until(64, 200, "t5_outputs");
    chk("t5_chan", f_chan(log_at(0)), 0);
    chk("t5_last63", f_last(log_at(63)), 1);
    chk("t5_last62", f_last(log_at(62)), 0);

    // Quantize boundaries.
    do_reset();
    s0_valid = 1; s0_data = 32'hFFFF0000;
    c = 0;
    while (out_log.size() < 2 && c < 50) begin
      step(); s0_data = (in_acc0 == 0) ? 32'hFFFF0000 : 32'h003F8000; c++;
    end
    chk("t6_i_max", f_i(log_at(0)), 32'h3FF);
    chk("t6_q_zero", f_q(log_at(0)), 32'h000);
    chk("t6_i_small", f_i(log_at(1)), 32'h000);
    chk("t6_q_half", f_q(log_at(1)), 32'h200);

    // Random stress.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      s0_valid = ($urandom_range(0, 3) != 0);
      s1_valid = ($urandom_range(0, 3) != 0);
      s0_data  = $urandom();
      s1_data  = $urandom();
      m_ready  = ($urandom_range(0, 3) != 0);
      step();
    end
    s0_valid = 0; s1_valid = 0; m_ready = 1;
    repeat (5) step();
    chk("t7_activity", out_log.size() > 100, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
